rdoq_last_pos_stream: RTL and testbench

RDOQ_LAST_POS_STREAM -- requirements
Module: rdoq_last_pos_stream

---
 rtl/rdoq_last_pos_stream.sv | 163 ++++++++++++++++
 tb/tb_rdoq_last_pos_stream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdoq_last_pos_stream.sv
// rdoq_last_pos_stream: streaming RDOQ last-significant-position search.
// Consumes coefficient beats in descending scan order and tracks the scan
// position whose "last" choice gives the lowest running RD cost.
// Optional feature macro: RDOQ_LPS_EARLY_TERM_EN -- stop scanning at the
// first significant coefficient with |level|>1 and drain the rest of the block.
module rdoq_last_pos_stream #(
  parameter int COST_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int CG_SIZE     = 16,
  parameter int LEVEL_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_WIDTH-1:0]         in_scan_pos,
  input  logic                          in_cg_start,
  input  logic                          in_cg_sig,
  input  logic                          in_last,
  input  logic signed [LEVEL_WIDTH-1:0] in_level,
  input  logic [COST_WIDTH-1:0]         in_cost_cg,
  input  logic [COST_WIDTH-1:0]         in_cost_coeff,
  input  logic [COST_WIDTH-1:0]         in_cost_coeff0,
  input  logic [COST_WIDTH-1:0]         in_cost_sig,
  input  logic [COST_WIDTH-1:0]         in_rate_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH:0]           out_best_idx_p1,
  output logic signed [COST_WIDTH+1:0]  out_best_cost,
  output logic                          busy
);

  localparam int CW = COST_WIDTH + 2;
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic signed [CW-1:0] COST_MAX = {1'b0, {(CW-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

  state_t state, state_nxt;

  // running accumulators
  logic signed [CW-1:0] base, base_nxt, best, best_nxt;
  logic [IW-1:0]        idx, idx_nxt;

  // beat cost terms, zero-extended into the signed arithmetic width
  logic signed [CW-1:0] c_cg, c_coeff, c_coeff0, c_sig, c_rate;
  logic signed [CW-1:0] base_cg, total;
  logic [IW-1:0]        pos_p1;
  logic                 accept, lvl_nz, term, load_out;

  assign c_cg     = $signed({2'b00, in_cost_cg});
  assign c_coeff  = $signed({2'b00, in_cost_coeff});
  assign c_coeff0 = $signed({2'b00, in_cost_coeff0});
  assign c_sig    = $signed({2'b00, in_cost_sig});
  assign c_rate   = $signed({2'b00, in_rate_last});
  assign pos_p1   = {1'b0, in_scan_pos} + IW'(1);
  assign lvl_nz   = (in_level != '0);

  assign in_ready  = (state == RUN) || (state == DRAIN);
  assign out_valid = (state == RESULT);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

`ifdef RDOQ_LPS_EARLY_TERM_EN
  localparam logic signed [LEVEL_WIDTH-1:0] LVL_ONE  = {{(LEVEL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [LEVEL_WIDTH-1:0] LVL_MONE = {LEVEL_WIDTH{1'b1}};
  logic lvl_big;
  assign lvl_big = (in_level > LVL_ONE) || (in_level < LVL_MONE);
`endif

  // accumulator update for the beat being accepted (or the start clear)
  always_comb begin
    base_nxt = base;
    best_nxt = best;
    idx_nxt  = idx;
    base_cg  = base;
    total    = '0;
    term     = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        base_nxt = '0;
        best_nxt = COST_MAX;
        idx_nxt  = '0;
      end
    end else if (state == RUN && accept) begin
      // CG header cost is charged whether or not the CG is significant
      base_cg  = in_cg_start ? (base - c_cg) : base;
      base_nxt = base_cg;
      total    = base_cg + c_rate - c_sig;
      if (in_cg_sig) begin
        if (lvl_nz) begin
          if (total < best) begin
            best_nxt = total;
            idx_nxt  = pos_p1;
          end
`ifdef RDOQ_LPS_EARLY_TERM_EN
          term = lvl_big;
`endif
          // past a terminating coefficient the base is never read again
          if (!term) base_nxt = base_cg + c_coeff0 - c_coeff;
        end else begin
          base_nxt = base_cg - c_sig;
        end
      end
    end
  end

  // next-state logic; load_out marks the edge that enters RESULT
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    assert (CG_SIZE == 4 || CG_SIZE == 16 || CG_SIZE == 64);
    unique case (state)
      IDLE:   if (start) state_nxt = RUN;
      RUN: begin
        if (accept) begin
          if (in_last) begin
            state_nxt = RESULT;
            load_out  = 1'b1;
          end else if (term) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          state_nxt = RESULT;
          load_out  = 1'b1;
        end
      end
      RESULT: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // accumulators and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base            <= '0;
      best            <= COST_MAX;
      idx             <= '0;
      out_best_idx_p1 <= '0;
      out_best_cost   <= '0;
    end else begin
      base <= base_nxt;
      best <= best_nxt;
      idx  <= idx_nxt;
      // in DRAIN best_nxt/idx_nxt equal the held values, so one load path serves both
      if (load_out) begin
        out_best_idx_p1 <= idx_nxt;
        out_best_cost   <= best_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rdoq_last_pos_stream.sv
// tb_rdoq_last_pos_stream: directed scenarios plus random blocks checked
// against a list-walking reference model of the last-position search.
module tb_rdoq_last_pos_stream;

  localparam int CW = 32;
  localparam int AW = 10;
  localparam int LW = 16;
  localparam int XW = CW + 2;
  localparam longint MAXP = (longint'(1) <<< (XW - 1)) - 1;
  localparam longint BIG = 64'hFFFF_FFFF;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [AW-1:0]        in_scan_pos = '0;
  logic                 in_cg_start = 1'b0, in_cg_sig = 1'b0, in_last = 1'b0;
  logic signed [LW-1:0] in_level = '0;
  logic [CW-1:0]        in_cost_cg = '0, in_cost_coeff = '0, in_cost_coeff0 = '0;
  logic [CW-1:0]        in_cost_sig = '0, in_rate_last = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [AW:0]          out_best_idx_p1;
  logic signed [XW-1:0] out_best_cost;
  logic                 busy;

  rdoq_last_pos_stream #(.COST_WIDTH(CW), .ADDR_WIDTH(AW), .CG_SIZE(16), .LEVEL_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_scan_pos(in_scan_pos), .in_cg_start(in_cg_start), .in_cg_sig(in_cg_sig),
    .in_last(in_last), .in_level(in_level),
    .in_cost_cg(in_cost_cg), .in_cost_coeff(in_cost_coeff), .in_cost_coeff0(in_cost_coeff0),
    .in_cost_sig(in_cost_sig), .in_rate_last(in_rate_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_best_idx_p1(out_best_idx_p1), .out_best_cost(out_best_cost), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     pos;
    bit     cgs, sig, last;
    int     lvl;
    longint cg, cf, cf0, cs, rl;
  } beat_t;

  beat_t  blk[$];
  int     checks = 0;
  int     passes = 0;
  longint exp_idx, exp_cost;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // two's complement wrap into the cost width
  function automatic longint wrap(input longint v);
    logic signed [XW-1:0] t;
    t = v[XW-1:0];
    return longint'(t);
  endfunction

  function automatic void add(input int pos, input bit cgs, input bit sig, input bit last, input int lvl,
                              input longint cg, input longint cf, input longint cf0,
                              input longint cs, input longint rl);
    beat_t b;
    b.pos = pos; b.cgs = cgs; b.sig = sig; b.last = last; b.lvl = lvl;
    b.cg = cg; b.cf = cf; b.cf0 = cf0; b.cs = cs; b.rl = rl;
    blk.push_back(b);
  endfunction

  // walk the beat list applying the cost rules directly
  function automatic void model();
    longint base = 0;
    longint best = MAXP;
    longint tot;
    int     idx = 0;
    foreach (blk[i]) begin
      if (blk[i].cgs) base = wrap(base - blk[i].cg);
      if (blk[i].sig) begin
        if (blk[i].lvl != 0) begin
          tot = wrap(base + blk[i].rl - blk[i].cs);
          if (tot < best) begin best = tot; idx = blk[i].pos + 1; end
`ifdef RDOQ_LPS_EARLY_TERM_EN
          if (blk[i].lvl > 1 || blk[i].lvl < -1) break;
`endif
          base = wrap(base + blk[i].cf0 - blk[i].cf);
        end else begin
          base = wrap(base - blk[i].cs);
        end
      end
    end
    exp_idx  = idx;
    exp_cost = best;
  endfunction

  // present one beat at a negedge and hold it until an edge accepts it
  task automatic drive_beat(input beat_t b);
    int n = 0;
    in_valid = 1'b1;
    in_scan_pos = AW'(b.pos); in_cg_start = b.cgs; in_cg_sig = b.sig; in_last = b.last;
    in_level = LW'(b.lvl);
    in_cost_cg = CW'(b.cg); in_cost_coeff = CW'(b.cf); in_cost_coeff0 = CW'(b.cf0);
    in_cost_sig = CW'(b.cs); in_rate_last = CW'(b.rl);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    chk("in_ready", in_ready, 1);
    @(negedge clk);
  endtask

  // full block: start, beats (optionally 1,0,1,0 valid), stall in RESULT, ack
  task automatic run_block(input string tag, input bit gap, input int stall,
                           input longint e_idx, input longint e_cost);
    int n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    foreach (blk[i]) begin
      drive_beat(blk[i]);
      if (gap) begin in_valid = 1'b0; @(negedge clk); end
    end
    in_valid = 1'b0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_idx"}, out_best_idx_p1, e_idx);
      chk({tag, "_hold_cost"}, out_best_cost, e_cost);
      start = (s == 1);  // must be ignored while the result is pending
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_idx"}, out_best_idx_p1, e_idx);
    chk({tag, "_cost"}, out_best_cost, e_cost);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  // pos 3..0, levels 1,0,1,0, cost_sig 5, rate_last 2 (optionally preceded by headers)
  function automatic void cg_1010(input int top);
    add(top,     1, 1, 0, 1, 0, 0, 0, 5, 2);
    add(top - 1, 0, 1, 0, 0, 0, 0, 0, 5, 2);
    add(top - 2, 0, 1, 0, 1, 0, 0, 0, 5, 2);
    add(top - 3, 0, 1, 1, 0, 0, 0, 0, 5, 2);
  endfunction

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", out_best_idx_p1, 0);
    chk("rst_cost", out_best_cost, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single CG: pos3 gives -3, level-0 at pos2 charges 5, so pos1 wins with -8
    blk.delete(); cg_1010(3);
    run_block("single_cg", 0, 0, 2, -8);

    // same stream with gapped valid and a 3-cycle result stall
    run_block("gapped", 1, 3, 2, -8);

    // all levels zero: no update
    blk.delete();
    for (int p = 15; p >= 0; p--) add(p, p == 15, 1, p == 0, 0, 0, 0, 0, 5, 2);
    run_block("all_zero", 0, 2, 0, MAXP);

    // header-only upper CG with cost_cg 7 shifts the result by -7
    blk.delete();
    add(7, 1, 0, 0, 0, 7, 0, 0, 0, 0);
    cg_1010(3);
    run_block("two_cg", 0, 0, 2, -15);

    // one beat that both opens a CG and ends the block: -3 + 1 - 2
    blk.delete();
    add(0, 1, 1, 1, 1, 3, 0, 0, 2, 1);
    run_block("start_last", 0, 0, 1, -4);

    // three max header costs wrap the base: 2^34 - 3*(2^32-1)
    blk.delete();
    add(15, 1, 0, 0, 0, BIG, 0, 0, 0, 0);
    add(11, 1, 0, 0, 0, BIG, 0, 0, 0, 0);
    add(7,  1, 0, 0, 0, BIG, 0, 0, 0, 0);
    add(3,  1, 1, 1, 1, 0, 0, 0, 0, 0);
    run_block("wrap", 0, 0, 4, 64'd4294967299);

`ifdef RDOQ_LPS_EARLY_TERM_EN
    // levels 1,2,1: level-2 at pos1 gives -4 and terminates; pos0 is drained
    blk.delete();
    add(2, 1, 1, 0, 1, 0, 1, 0, 5, 2);
    add(1, 0, 1, 0, 2, 0, 1, 0, 5, 2);
    add(0, 0, 1, 1, 1, 0, 1, 0, 5, 2);
    run_block("early_term", 0, 0, 2, -4);
    run_block("early_term_stall", 0, 5, 2, -4);
`endif

    // reset after 2 of 4 beats abandons the block
    blk.delete(); cg_1010(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_beat(blk[0]);
    drive_beat(blk[1]);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_idx", out_best_idx_p1, 0);
    chk("midrst_cost", out_best_cost, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("midrst_no_valid", out_valid, 0);
      @(negedge clk);
    end
    run_block("after_rst", 0, 1, 2, -8);

    // random blocks against the reference model
    for (int r = 0; r < 24; r++) begin
      int ncg = $urandom_range(1, 4);
      int pos = ncg * 4 - 1;
      bit big = ($urandom_range(0, 4) == 0);
      blk.delete();
      for (int c = 0; c < ncg; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          add(pos, 1, 0, 0, 0, big ? longint'($urandom) : longint'($urandom_range(0, 200)), 0, 0, 0, 0);
          pos -= 4;
        end else begin
          for (int k = 0; k < 4; k++) begin
            int lvl = $urandom_range(0, 1) ? 0 : int'($urandom_range(0, 6)) - 3;
            if (big)
              add(pos, k == 0, 1, 0, lvl, longint'($urandom), longint'($urandom), longint'($urandom),
                  longint'($urandom), longint'($urandom));
            else
              add(pos, k == 0, 1, 0, lvl, $urandom_range(0, 200), $urandom_range(0, 200),
                  $urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 200));
            pos--;
          end
        end
      end
      blk[blk.size() - 1].last = 1'b1;
      model();
      run_block("random", $urandom_range(0, 1), $urandom_range(0, 4), exp_idx, exp_cost);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
